// File: rtl/metadata_fetcher_pkg.sv
// Shared types and defaults for the X-bitmap metadata fetch path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: chunk/word default widths, scheduler parameter struct,
//           streamer control struct, fetcher state encoding.
package metadata_fetcher_pkg;

    // Defaults shared with the Y data scheduler so both sides agree on chunk geometry.
    localparam int unsigned META_CHUNK_SIZE_DEF = 512;
    localparam int unsigned MEM_WIDTH_DEF       = 32;
    localparam int unsigned ADDR_WIDTH_DEF      = 32;

    typedef struct packed {
        logic [31:0] base_address;  // byte address of bitmap word 0
        logic [15:0] tot_words;     // bitmap length in MEM_WIDTH words, >= 1
    } meta_param_t;

    // Streamer load descriptor: one linear burst uses only dimension 0.
    typedef struct packed {
        logic        req_start;
        logic [31:0] base_addr;
        logic [31:0] tot_len;
        logic [31:0] d0_len;
        logic [31:0] d0_stride;
        logic [31:0] d1_len;
        logic [31:0] d1_stride;
        logic [31:0] d2_stride;
        logic [1:0]  dim_enable_1h;
    } hci_streamer_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIG  = 2'd1,
        ST_STREAM  = 2'd2,
        ST_DELIVER = 2'd3
    } meta_state_e;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/metadata_fetcher_word_packer.sv
// Packs streamed MEM_WIDTH words into one META_CHUNK_SIZE chunk buffer.
// Latency: word written on the accepting edge; last_o is combinational on the final accept.
// Backpressure: none internally; the caller gates accept_i with its ready.
// Ports: start_i zero-pads words >= len_i and rewinds the counter; accept_i writes
//        data_i at the current word slot; chunk_next_o is the buffer including this
//        cycle's write so the caller can capture the full chunk on the last accept.
module meta_word_packer
    import metadata_fetcher_pkg::*;
#(
    parameter int unsigned META_CHUNK_SIZE = META_CHUNK_SIZE_DEF,
    parameter int unsigned MEM_WIDTH       = MEM_WIDTH_DEF
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          clear_i,
    input  logic                                          start_i,
    input  logic [$clog2(META_CHUNK_SIZE/MEM_WIDTH):0]    len_i,
    input  logic                                          accept_i,
    input  logic [MEM_WIDTH-1:0]                          data_i,
    output logic                                          last_o,
    output logic [META_CHUNK_SIZE-1:0]                    chunk_next_o
);

    localparam int unsigned WORDS = META_CHUNK_SIZE / MEM_WIDTH;
    localparam int unsigned CNT_W = $clog2(WORDS) + 1;

    logic [CNT_W-1:0]                  word_cnt_q, word_cnt_d;
    logic [WORDS-1:0][MEM_WIDTH-1:0]   chunk_buf_q, chunk_buf_d;

    always_comb begin
        word_cnt_d  = word_cnt_q;
        chunk_buf_d = chunk_buf_q;
        last_o      = 1'b0;

        if (start_i) begin
            word_cnt_d = '0;
            // Slots beyond this burst's length stay zero so a short tail chunk is padded.
            for (int w = 0; w < int'(WORDS); w++) begin
                if (CNT_W'(w) >= len_i) begin
                    chunk_buf_d[w] = '0;
                end
            end
        end else if (accept_i) begin
            // Compare against each slot rather than indexing: the counter is one bit
            // wider than the slot index so it can hold the full count.
            for (int w = 0; w < int'(WORDS); w++) begin
                if (word_cnt_q == CNT_W'(w)) begin
                    chunk_buf_d[w] = data_i;
                end
            end
            word_cnt_d = word_cnt_q + CNT_W'(1);
            last_o     = (word_cnt_d == len_i);
        end

        if (clear_i) begin
            word_cnt_d  = '0;
            chunk_buf_d = '0;
            last_o      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_cnt_q  <= '0;
            chunk_buf_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            chunk_buf_q <= chunk_buf_d;
        end
    end

    assign chunk_next_o = chunk_buf_d;

endmodule

// File: rtl/metadata_fetcher.sv
// Fetches the X bitmap one chunk per scheduler request edge, wrapping at the end.
// Latency: edge at t -> req_start at t+1 -> words from t+2 -> meta_valid_o one cycle after last word.
// Backpressure: ready_o only in STREAM; extra request edges collapse into one pending request.
// Ports: meta_req_i/params_i from the Y scheduler; config_o to the HCI source streamer;
//        data_i/valid_i/ready_o streamed words; metadata_chunk_o/meta_valid_o/done_o back
//        to the scheduler (done_o marks the chunk that finishes the bitmap).
module metadata_fetcher
    import metadata_fetcher_pkg::*;
#(
    parameter int unsigned META_CHUNK_SIZE = META_CHUNK_SIZE_DEF,
    parameter int unsigned MEM_WIDTH       = MEM_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        meta_req_i,
    input  meta_param_t                 params_i,
    output hci_streamer_ctrl_t          config_o,
    input  logic [MEM_WIDTH-1:0]        data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [META_CHUNK_SIZE-1:0]  metadata_chunk_o,
    output logic                        meta_valid_o,
    output logic                        done_o
);

    localparam int unsigned WORDS       = META_CHUNK_SIZE / MEM_WIDTH;
    localparam int unsigned CHUNK_BYTES = META_CHUNK_SIZE / 8;
    localparam int unsigned WORD_BYTES  = MEM_WIDTH / 8;
    localparam int unsigned LEN_W       = $clog2(WORDS) + 1;
    localparam int unsigned CHUNK_SHIFT = $clog2(CHUNK_BYTES);

    meta_state_e               state_q, state_d;
    logic                      req_q, req_d;
    logic                      pending_q, pending_d;
    logic [15:0]               chunk_idx_q, chunk_idx_d;
    logic [15:0]               words_left_q, words_left_d;
    logic [LEN_W-1:0]          len_q, len_d;
    hci_streamer_ctrl_t        cfg_q, cfg_d;
    logic                      ready_q, ready_d;
    logic                      meta_valid_q, meta_valid_d;
    logic                      done_q, done_d;
    logic [META_CHUNK_SIZE-1:0] chunk_q, chunk_d;

    logic                      req_edge;
    logic [15:0]               words_avail;
    logic [LEN_W-1:0]          fetch_len;
    logic [ADDR_WIDTH-1:0]     chunk_offset;
    logic [ADDR_WIDTH-1:0]     fetch_base;

    logic                      pack_start;
    logic                      pack_accept;
    logic                      pack_last;
    logic [META_CHUNK_SIZE-1:0] pack_chunk_next;

    assign req_edge    = meta_req_i & ~req_q;
    assign pack_start  = (state_q == ST_CONFIG);
    assign pack_accept = valid_i & ready_q;

    // Burst geometry for the next chunk; only consumed on the IDLE -> CONFIG step,
    // which is where params_i is sampled. Chunk 0 starts a new pass over the bitmap.
    always_comb begin
        words_avail = (chunk_idx_q == 16'd0) ? params_i.tot_words : words_left_q;
        fetch_len   = (words_avail >= 16'(WORDS)) ? LEN_W'(WORDS) : LEN_W'(words_avail);
        if (is_pow2(CHUNK_BYTES)) begin
            chunk_offset = ADDR_WIDTH'(chunk_idx_q) << CHUNK_SHIFT;
        end else begin
            chunk_offset = ADDR_WIDTH'(chunk_idx_q) * ADDR_WIDTH'(CHUNK_BYTES);
        end
        fetch_base = ADDR_WIDTH'(params_i.base_address) + chunk_offset;
    end

    always_comb begin
        state_d      = state_q;
        req_d        = meta_req_i;
        pending_d    = pending_q;
        chunk_idx_d  = chunk_idx_q;
        words_left_d = words_left_q;
        len_d        = len_q;
        cfg_d        = cfg_q;
        cfg_d.req_start = 1'b0;
        ready_d      = ready_q;
        meta_valid_d = 1'b0;
        done_d       = 1'b0;
        chunk_d      = chunk_q;

        // A request arriving while busy is remembered once; later ones are dropped.
        if (req_edge && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (req_edge || pending_q) begin
                    state_d         = ST_CONFIG;
                    pending_d       = 1'b0;
                    words_left_d    = words_avail;
                    len_d           = fetch_len;
                    // Descriptor is registered here so it is presented during CONFIG.
                    cfg_d           = '0;
                    cfg_d.req_start = 1'b1;
                    cfg_d.base_addr = 32'(fetch_base);
                    cfg_d.tot_len   = 32'(fetch_len);
                    cfg_d.d0_len    = 32'(fetch_len);
                    cfg_d.d0_stride = 32'(WORD_BYTES);
                end
            end
            ST_CONFIG: begin
                state_d = ST_STREAM;
                ready_d = 1'b1;
            end
            ST_STREAM: begin
                if (pack_last) begin
                    state_d      = ST_DELIVER;
                    ready_d      = 1'b0;
                    meta_valid_d = 1'b1;
                    done_d       = (words_left_q == 16'(len_q));
                    chunk_d      = pack_chunk_next;
                end
            end
            ST_DELIVER: begin
                state_d = ST_IDLE;
                if (done_q) begin
                    chunk_idx_d  = 16'd0;
                    words_left_d = 16'd0;
                end else begin
                    chunk_idx_d  = chunk_idx_q + 16'd1;
                    words_left_d = words_left_q - 16'(len_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_i) begin
            state_d      = ST_IDLE;
            req_d        = 1'b0;
            pending_d    = 1'b0;
            chunk_idx_d  = 16'd0;
            words_left_d = 16'd0;
            len_d        = '0;
            cfg_d        = '0;
            ready_d      = 1'b0;
            meta_valid_d = 1'b0;
            done_d       = 1'b0;
            chunk_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            pending_q    <= 1'b0;
            chunk_idx_q  <= 16'd0;
            words_left_q <= 16'd0;
            len_q        <= '0;
            cfg_q        <= '0;
            ready_q      <= 1'b0;
            meta_valid_q <= 1'b0;
            done_q       <= 1'b0;
            chunk_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pending_q    <= pending_d;
            chunk_idx_q  <= chunk_idx_d;
            words_left_q <= words_left_d;
            len_q        <= len_d;
            cfg_q        <= cfg_d;
            ready_q      <= ready_d;
            meta_valid_q <= meta_valid_d;
            done_q       <= done_d;
            chunk_q      <= chunk_d;
        end
    end

    meta_word_packer #(
        .META_CHUNK_SIZE (META_CHUNK_SIZE),
        .MEM_WIDTH       (MEM_WIDTH)
    ) u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .start_i      (pack_start),
        .len_i        (len_q),
        .accept_i     (pack_accept),
        .data_i       (data_i),
        .last_o       (pack_last),
        .chunk_next_o (pack_chunk_next)
    );

    assign config_o         = cfg_q;
    assign ready_o          = ready_q;
    assign metadata_chunk_o = chunk_q;
    assign meta_valid_o     = meta_valid_q;
    assign done_o           = done_q;

endmodule
